// File: rtl/sha256_w_sched_seq_if.sv
// SHA-256 message-schedule handshake bundle.
// Groups the block-load request and the W-word output stream.
//   start    : request to load block_in (sampled only while idle)
//   block_in : 512-bit message block, W0 in bits [511:480]
//   w_ready  : downstream accepts w_out this cycle
//   w_valid  : w_out / w_idx carry a schedule word
//   w_out    : schedule word W[t]
//   w_idx    : index t of w_out
//   busy     : scheduler is not idle
//   done     : one-cycle pulse after W63 is accepted
// Valid/ready: a word moves when w_valid and w_ready are both high in the
// same cycle; while w_ready is low the word and its index are held stable.
// Modports: slave is the scheduler, master is whoever drives it.
interface sha256_w_sched_seq_if;
    logic         start;
    logic [511:0] block_in;
    logic         w_ready;
    logic         w_valid;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         busy;
    logic         done;

    modport slave (
        input  start, block_in, w_ready,
        output w_valid, w_out, w_idx, busy, done
    );

    modport master (
        output start, block_in, w_ready,
        input  w_valid, w_out, w_idx, busy, done
    );
endinterface

// File: rtl/sha256_w_sched_seq.sv
// SHA-256 message schedule generator, one word per accepted handshake.
// Loads a 512-bit block into a 16-word sliding window and streams
// W0..W63 on a valid/ready interface, expanding W16..W63 on the fly.
// Ports:
//   CLK       : rising-edge clock
//   RST       : asynchronous active-high reset
//   bus       : handshake bundle (slave side), see sha256_w_sched_seq_if
//   fsm_state : current FSM state (0 IDLE, 1 EXPAND, 2 DONE) for observation
module sha256_w_sched_seq (
    input  logic                       CLK,
    input  logic                       RST,
    sha256_w_sched_seq_if.slave        bus,
    output logic [1:0]                 fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] win [16];
    logic [5:0]  t;
    logic        accept;
    logic        xfer;
    logic        last;
    logic [31:0] w_new;
    logic [31:0] w_valid_q;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Next schedule word; win[0] is W[t], so this produces W[t+16].
    assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    assign last  = (t == 6'd63);

    assign fsm_state = state;

    // FSM next-state and handshake qualifiers.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                // w_valid is always high in EXPAND, so ready alone qualifies a transfer.
                if (bus.w_ready) begin
                    xfer = 1'b1;
                    if (last) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Window, index and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            t           <= '0;
            bus.w_out   <= '0;
            bus.w_idx   <= '0;
            bus.w_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 16; i++) begin
                    win[i] <= bus.block_in[511 - 32*i -: 32];
                end
                t           <= '0;
                bus.w_out   <= bus.block_in[511:480];
                bus.w_idx   <= '0;
                bus.w_valid <= 1'b1;
                bus.busy    <= 1'b1;
                bus.done    <= 1'b0;
            end else if (xfer) begin
                for (int i = 0; i < 15; i++) begin
                    win[i] <= win[i+1];
                end
                win[15] <= w_new;
                if (last) begin
                    // Keep W63 and index 63 visible; t does not wrap.
                    bus.w_valid <= 1'b0;
                    bus.done    <= 1'b1;
                end else begin
                    t         <= t + 6'd1;
                    bus.w_out <= win[1];
                    bus.w_idx <= t + 6'd1;
                end
            end else if (state == DONE) begin
                bus.done <= 1'b0;
                bus.busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_w_sched_seq.sv
// Testbench for sha256_w_sched_seq: directed "abc" vectors, stall, held
// start, mid-block reset and randomized blocks against a schedule model.
module tb_sha256_w_sched_seq;

    logic       clk;
    logic       rst;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_w [64];
    logic [31:0] exp_q [$];

    sha256_w_sched_seq_if bus ();

    sha256_w_sched_seq dut (
        .CLK       (clk),
        .RST       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic compute_ref(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) ref_w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            ref_w[i] = ssig1(ref_w[i-2]) + ref_w[i-7] + ssig0(ref_w[i-15]) + ref_w[i-16];
    endtask

    function automatic logic [511:0] abc_block();
        return {32'h61626380, 448'b0, 32'h00000018};
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
        return b;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.block_in = '0;
        bus.w_ready = 1'b0;
        #1 rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({bus.w_valid, bus.busy, bus.done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.w_valid, bus.busy, bus.done});
        end
        n_checks++;
        if ({bus.w_out, bus.w_idx} !== 38'd0) begin
            n_fail++; $display("FAIL reset_data: got w_out=%h w_idx=%0d want 0/0", bus.w_out, bus.w_idx);
        end
        rst = 1'b0;
        tick(); tick();
        n_checks++;
        if ({bus.w_valid, bus.busy, bus.done} !== 3'b000) begin
            n_fail++; $display("FAIL idle_after_reset: got %b want 000", {bus.w_valid, bus.busy, bus.done});
        end
    endtask

    task automatic test_abc();
        compute_ref(abc_block());
        tick();
        bus.block_in = abc_block();
        bus.start = 1'b1;
        bus.w_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            n_checks++;
            if (bus.w_valid !== 1'b1 || bus.w_idx !== 6'(c-1) || bus.w_out !== ref_w[c-1]) begin
                n_fail++;
                $display("FAIL abc_word cycle %0d: got v=%b idx=%0d w=%h want v=1 idx=%0d w=%h",
                         c, bus.w_valid, bus.w_idx, bus.w_out, c-1, ref_w[c-1]);
            end
            if (c == 1) begin
                n_checks++;
                if (bus.w_out !== 32'h61626380) begin
                    n_fail++; $display("FAIL abc_w0: got %h want 61626380", bus.w_out);
                end
            end
            if (c == 16) begin
                n_checks++;
                if (bus.w_out !== 32'h00000018) begin
                    n_fail++; $display("FAIL abc_w15: got %h want 00000018", bus.w_out);
                end
            end
            if (c == 17) begin
                n_checks++;
                if (bus.w_out !== 32'h61626380) begin
                    n_fail++; $display("FAIL abc_w16: got %h want 61626380", bus.w_out);
                end
            end
            if (c == 18) begin
                n_checks++;
                if (bus.w_out !== 32'h000F0000) begin
                    n_fail++; $display("FAIL abc_w17: got %h want 000f0000", bus.w_out);
                end
            end
            tick();
        end
        // cycle N+65
        n_checks++;
        if ({bus.done, bus.busy, bus.w_valid} !== 3'b110) begin
            n_fail++; $display("FAIL abc_done: got done,busy,valid=%b want 110", {bus.done, bus.busy, bus.w_valid});
        end
        tick();
        n_checks++;
        if ({bus.done, bus.busy, bus.w_valid} !== 3'b000) begin
            n_fail++; $display("FAIL abc_idle: got done,busy,valid=%b want 000", {bus.done, bus.busy, bus.w_valid});
        end
        n_checks++;
        if (bus.w_out !== ref_w[63] || bus.w_idx !== 6'd63) begin
            n_fail++; $display("FAIL abc_retain: got w=%h idx=%0d want w=%h idx=63", bus.w_out, bus.w_idx, ref_w[63]);
        end
    endtask

    task automatic test_stall();
        int cyc;
        int eidx;
        int stalls;
        compute_ref(abc_block());
        tick();
        bus.block_in = abc_block();
        bus.start = 1'b1;
        bus.w_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1; eidx = 0; stalls = 0;
        while (eidx < 64 && cyc < 200) begin
            n_checks++;
            if (bus.w_valid !== 1'b1 || bus.w_idx !== 6'(eidx) || bus.w_out !== ref_w[eidx]) begin
                n_fail++;
                $display("FAIL stall_word cycle %0d: got v=%b idx=%0d w=%h want v=1 idx=%0d w=%h",
                         cyc, bus.w_valid, bus.w_idx, bus.w_out, eidx, ref_w[eidx]);
            end
            if (eidx == 5 && stalls < 3) begin
                bus.w_ready = 1'b0;
                stalls++;
            end else begin
                bus.w_ready = 1'b1;
                eidx++;
            end
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc !== 68 || bus.done !== 1'b1) begin
            n_fail++; $display("FAIL stall_done: got cycle=%0d done=%b want cycle=68 done=1", cyc, bus.done);
        end
        tick();
    endtask

    task automatic test_start_held();
        logic [511:0] blk1;
        logic [511:0] blk2;
        blk1 = rand_block();
        blk2 = rand_block();
        compute_ref(blk1);
        tick();
        bus.block_in = blk1;
        bus.start = 1'b1;
        bus.w_ready = 1'b1;
        tick();
        bus.block_in = blk2;
        for (int c = 1; c <= 64; c++) begin
            n_checks++;
            if (bus.w_idx !== 6'(c-1) || bus.w_out !== ref_w[c-1]) begin
                n_fail++;
                $display("FAIL held_blk1 cycle %0d: got idx=%0d w=%h want idx=%0d w=%h",
                         c, bus.w_idx, bus.w_out, c-1, ref_w[c-1]);
            end
            tick();
        end
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++; $display("FAIL held_done1: got %b want 1", bus.done);
        end
        tick();
        n_checks++;
        if ({bus.busy, bus.w_valid} !== 2'b00) begin
            n_fail++; $display("FAIL held_idle: got busy,valid=%b want 00", {bus.busy, bus.w_valid});
        end
        tick();
        bus.start = 1'b0;
        n_checks++;
        if (bus.w_valid !== 1'b1 || bus.w_idx !== 6'd0 || bus.w_out !== blk2[511:480]) begin
            n_fail++;
            $display("FAIL held_accept2: got v=%b idx=%0d w=%h want v=1 idx=0 w=%h",
                     bus.w_valid, bus.w_idx, bus.w_out, blk2[511:480]);
        end
        compute_ref(blk2);
        for (int k = 1; k < 64; k++) begin
            tick();
            n_checks++;
            if (bus.w_idx !== 6'(k) || bus.w_out !== ref_w[k]) begin
                n_fail++;
                $display("FAIL held_blk2 idx %0d: got idx=%0d w=%h want w=%h", k, bus.w_idx, bus.w_out, ref_w[k]);
            end
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++; $display("FAIL held_done2: got %b want 1", bus.done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        compute_ref(abc_block());
        tick();
        bus.block_in = abc_block();
        bus.start = 1'b1;
        bus.w_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 30; c++) tick();
        n_checks++;
        if (bus.w_idx !== 6'd30 || bus.w_out !== ref_w[30]) begin
            n_fail++; $display("FAIL rmid_pre: got idx=%0d w=%h want idx=30 w=%h", bus.w_idx, bus.w_out, ref_w[30]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.w_valid, bus.busy, bus.done, bus.w_out, bus.w_idx} !== 41'd0) begin
            n_fail++;
            $display("FAIL rmid_async: got v=%b busy=%b done=%b w=%h idx=%0d want all 0",
                     bus.w_valid, bus.busy, bus.done, bus.w_out, bus.w_idx);
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_nodone: got done=%b busy=%b want 0/0", bus.done, bus.busy);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rmid_nodone_after: got done=%b want 0", bus.done);
        end
        test_abc();
    endtask

    task automatic test_random();
        logic [511:0] blk;
        int cyc;
        int xfers;
        int dones;
        for (int nb = 0; nb < 6; nb++) begin
            blk = rand_block();
            compute_ref(blk);
            exp_q = {};
            for (int i = 0; i < 64; i++) exp_q.push_back(ref_w[i]);
            tick();
            bus.block_in = blk;
            bus.start = 1'b1;
            bus.w_ready = 1'($urandom_range(0, 1));
            tick();
            xfers = 0; dones = 0; cyc = 0;
            while (dones == 0 && cyc < 2000) begin
                if (bus.done) begin
                    dones++;
                    bus.start = 1'b0;
                end else begin
                    // noise on start/block_in while busy must be ignored
                    bus.start = 1'($urandom_range(0, 1));
                    bus.block_in = {16{$urandom()}};
                end
                bus.w_ready = ($urandom_range(0, 3) != 0);
                if (bus.w_valid && bus.w_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL rand_extra blk %0d: got transfer idx=%0d want none", nb, bus.w_idx);
                    end else begin
                        if (bus.w_out !== exp_q[0] || bus.w_idx !== 6'(xfers)) begin
                            n_fail++;
                            $display("FAIL rand_word blk %0d: got idx=%0d w=%h want idx=%0d w=%h",
                                     nb, bus.w_idx, bus.w_out, xfers, exp_q[0]);
                        end
                        void'(exp_q.pop_front());
                    end
                    xfers++;
                end
                tick();
                cyc++;
            end
            n_checks++;
            if (dones != 1 || xfers != 64 || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL rand_count blk %0d: got dones=%0d xfers=%0d left=%0d want 1/64/0",
                         nb, dones, xfers, exp_q.size());
            end
            n_checks++;
            if ({bus.done, bus.busy, bus.w_valid} !== 3'b000) begin
                n_fail++; $display("FAIL rand_idle blk %0d: got done,busy,valid=%b want 000", nb,
                                   {bus.done, bus.busy, bus.w_valid});
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_abc();
        test_stall();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
